instr_decode_stage: RTL and testbench

Parametrised, elastic RISC-V instruction decode stage. It sits between fetch and execute. Each accepted 32-bit instruction is classified into `common::instruction_op_type`, and register indices and a sign-extended immediate are extracted. A two-entry skid buffer with a valid/ready handshake provides full-throughput backpressure, and the block keeps a saturating illegal-instruction counter. Floating-point opcodes are enabled or disabled at elaboration time.

---
 rtl/instr_decode_stage_pkg.sv | 55 +++++
 rtl/instr_decode_stage_field_decoder.sv | 108 ++++++++++
 rtl/instr_decode_stage.sv | 143 ++++++++++++++
 tb/tb_instr_decode_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_stage_pkg.sv
// Shared types for the decode stage: op-type classes, opcode map, decoded entry layout.
package common;

    localparam logic RESET                 = 1'b0;
    localparam int   INSTRUCTION_WIDTH     = 32;
    localparam int   PROGRAM_ADDRESS_WIDTH = 32;
    localparam int   ILLEGAL_COUNT_W       = 8;

    typedef enum logic [2:0] {
        R_TYPE   = 3'd0,
        I_TYPE   = 3'd1,
        S_TYPE   = 3'd2,
        B_TYPE   = 3'd3,
        U_TYPE   = 3'd4,
        J_TYPE   = 3'd5,
        SYS_TYPE = 3'd6
    } instruction_op_type;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_U_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_U_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_MADD     = 7'b1000011;
    localparam logic [6:0] OPC_MSUB     = 7'b1000111;
    localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
    localparam logic [6:0] OPC_NMADD    = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_J_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // imm holds the 32-bit sign-extended immediate; the top widens it to XLEN.
    typedef struct packed {
        instruction_op_type                op_type;
        logic [6:0]                        opcode;
        logic [4:0]                        rd;
        logic [4:0]                        rs1;
        logic [4:0]                        rs2;
        logic [31:0]                       imm;
        logic [PROGRAM_ADDRESS_WIDTH-1:0]  pc;
        logic                              illegal;
    } decoded_instr_t;

endpackage

// File: rtl/instr_decode_stage_field_decoder.sv
// Combinational RV32 field decoder: classifies the opcode and extracts registers and immediate.
module instr_field_decoder
    import common::*;
#(
    parameter int XLEN      = 32,
    parameter bit ENABLE_FP = 1'b0
) (
    input  logic [INSTRUCTION_WIDTH-1:0] i_instr,
    output decoded_instr_t               o_dec
);

    // Immediates are narrower than any legal XLEN, so the sign always comes from bit 31.
    localparam int SIGN_BIT = (XLEN >= 32) ? 31 : XLEN - 1;

    logic        w_sign;
    logic [6:0]  w_opc;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_sign  = i_instr[SIGN_BIT];
    assign w_opc   = i_instr[6:0];
    assign w_imm_i = {{20{w_sign}}, i_instr[31:20]};
    assign w_imm_s = {{20{w_sign}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{w_sign}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {{11{w_sign}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    always_comb begin
        o_dec         = '0;
        o_dec.opcode  = w_opc;
        o_dec.op_type = R_TYPE;
        unique case (w_opc)
            OPC_OP: begin
                o_dec.rd  = i_instr[11:7];
                o_dec.rs1 = i_instr[19:15];
                o_dec.rs2 = i_instr[24:20];
            end
            OPC_OP_FP, OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin
                if (ENABLE_FP) begin
                    o_dec.rd  = i_instr[11:7];
                    o_dec.rs1 = i_instr[19:15];
                    o_dec.rs2 = i_instr[24:20];
                end else begin
                    o_dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM, OPC_JALR, OPC_LOAD: begin
                o_dec.op_type = I_TYPE;
                o_dec.rd      = i_instr[11:7];
                o_dec.rs1     = i_instr[19:15];
                o_dec.imm     = w_imm_i;
            end
            OPC_LOAD_FP: begin
                if (ENABLE_FP) begin
                    o_dec.op_type = I_TYPE;
                    o_dec.rd      = i_instr[11:7];
                    o_dec.rs1     = i_instr[19:15];
                    o_dec.imm     = w_imm_i;
                end else begin
                    o_dec.illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                o_dec.op_type = S_TYPE;
                o_dec.rs1     = i_instr[19:15];
                o_dec.rs2     = i_instr[24:20];
                o_dec.imm     = w_imm_s;
            end
            OPC_STORE_FP: begin
                if (ENABLE_FP) begin
                    o_dec.op_type = S_TYPE;
                    o_dec.rs1     = i_instr[19:15];
                    o_dec.rs2     = i_instr[24:20];
                    o_dec.imm     = w_imm_s;
                end else begin
                    o_dec.illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                o_dec.op_type = B_TYPE;
                o_dec.rs1     = i_instr[19:15];
                o_dec.rs2     = i_instr[24:20];
                o_dec.imm     = w_imm_b;
            end
            OPC_U_LUI, OPC_U_AUIPC: begin
                o_dec.op_type = U_TYPE;
                o_dec.rd      = i_instr[11:7];
                o_dec.imm     = w_imm_u;
            end
            OPC_J_JAL: begin
                o_dec.op_type = J_TYPE;
                o_dec.rd      = i_instr[11:7];
                o_dec.imm     = w_imm_j;
            end
            OPC_SYSTEM: begin
                o_dec.op_type = SYS_TYPE;
                o_dec.rd      = i_instr[11:7];
                o_dec.rs1     = i_instr[19:15];
                o_dec.imm     = w_imm_i;
            end
            default: o_dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Elastic decode stage: field decoder feeding a two-entry skid buffer plus an illegal counter.
module instr_decode_stage
    import common::*;
#(
    parameter int XLEN      = 32,
    parameter int INSTR_W   = INSTRUCTION_WIDTH,
    parameter int PC_W      = PROGRAM_ADDRESS_WIDTH,
    parameter bit ENABLE_FP = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_op_type,
    output logic [6:0]                 out_opcode,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [XLEN-1:0]            out_imm,
    output logic [PC_W-1:0]            out_pc,
    output logic                       out_illegal,
    output logic [ILLEGAL_COUNT_W-1:0] illegal_count,
    output logic [1:0]                 dbg_state
);

    buf_state_t                 r_state;
    buf_state_t                 w_state_next;
    decoded_instr_t             r_main;
    decoded_instr_t             r_skid;
    decoded_instr_t             w_fields;
    decoded_instr_t             w_dec;
    logic [ILLEGAL_COUNT_W-1:0] r_count;
    logic                       w_acc;
    logic                       w_pop;
    logic                       w_load_main_dec;
    logic                       w_load_main_skid;
    logic                       w_load_skid;

    instr_field_decoder #(
        .XLEN      (XLEN),
        .ENABLE_FP (ENABLE_FP)
    ) u_field_decoder (
        .i_instr (in_instr),
        .o_dec   (w_fields)
    );

    always_comb begin
        w_dec    = w_fields;
        w_dec.pc = PROGRAM_ADDRESS_WIDTH'(in_pc);
    end

    // A transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and a presented entry holds until taken.
    assign in_ready  = (r_state != BUF_TWO) && (reset != RESET);
    assign out_valid = (r_state != BUF_EMPTY);
    assign w_acc     = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        w_state_next     = r_state;
        w_load_main_dec  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_next = BUF_EMPTY;
        end else begin
            unique case (r_state)
                BUF_EMPTY: begin
                    if (w_acc) begin
                        w_state_next    = BUF_ONE;
                        w_load_main_dec = 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (w_acc && w_pop) begin
                        w_load_main_dec = 1'b1;
                    end else if (w_acc) begin
                        w_state_next = BUF_TWO;
                        w_load_skid  = 1'b1;
                    end else if (w_pop) begin
                        w_state_next = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (w_pop) begin
                        w_state_next     = BUF_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_next = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset == RESET) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset == RESET) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_dec) begin
                r_main <= w_dec;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset == RESET) begin
            r_count <= '0;
        end else if (w_acc && !flush && w_dec.illegal && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign out_op_type   = r_main.op_type;
    assign out_opcode    = r_main.opcode;
    assign out_rd        = r_main.rd;
    assign out_rs1       = r_main.rs1;
    assign out_rs2       = r_main.rs2;
    assign out_imm       = XLEN'($signed(r_main.imm));
    assign out_pc        = PC_W'(r_main.pc);
    assign out_illegal   = r_main.illegal;
    assign illegal_count = r_count;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: directed vectors, backpressure, flush and reset.
module tb_instr_decode_stage;
  import common::*;

  localparam int EW = 90;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_op_type;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic        out_illegal;
  logic [7:0]  illegal_count;
  logic [1:0]  dbg_state;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] pc_ctr = 32'h1000;

  instr_decode_stage dut (
    .clk           (clk),
    .reset         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_op_type   (out_op_type),
    .out_opcode    (out_opcode),
    .out_rd        (out_rd),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_imm       (out_imm),
    .out_pc        (out_pc),
    .out_illegal   (out_illegal),
    .illegal_count (illegal_count),
    .dbg_state     (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] pack(input logic [2:0] op, input logic [6:0] opc,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [31:0] imm,
                                         input logic [31:0] pc, input logic ill);
    return {op, opc, rd, rs1, rs2, imm, pc, ill};
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: pop and compare whenever an entry is consumed
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none",
                 pack(out_op_type, out_opcode, out_rd, out_rs1, out_rs2, out_imm, out_pc, out_illegal));
      end else begin
        chk("pop", pack(out_op_type, out_opcode, out_rd, out_rs1, out_rs2, out_imm, out_pc, out_illegal),
            exp_q.pop_front());
      end
    end
  end

  // driver: present one instruction and push its expected decode when accepted
  task automatic send(input logic [31:0] instr, input logic [2:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic ill);
    int waited = 0;
    logic [31:0] v;
    v = instr;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc_ctr;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accept instr=%h", instr);
    end else begin
      exp_q.push_back(pack(op, v[6:0], rd, rs1, rs2, imm, pc_ctr, ill));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pc_ctr   = pc_ctr + 32'd4;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic send_addi(); send(32'hFFF00093, I_TYPE, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0); endtask
  task automatic send_sw();   send(32'h0020A423, S_TYPE, 5'd0, 5'd1, 5'd2, 32'h00000008, 1'b0); endtask
  task automatic send_add();  send(32'h002081B3, R_TYPE, 5'd3, 5'd1, 5'd2, 32'h00000000, 1'b0); endtask
  task automatic send_lw();   send(32'hFF012383, I_TYPE, 5'd7, 5'd2, 5'd0, 32'hFFFFFFF0, 1'b0); endtask
  task automatic send_jal();  send(32'h008000EF, J_TYPE, 5'd1, 5'd0, 5'd0, 32'h00000008, 1'b0); endtask
  task automatic send_ill0(); send(32'h00000000, R_TYPE, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1); endtask
  task automatic send_ill_fp(); send(32'h00000053, R_TYPE, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1); endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_instr  = '0;
    in_pc     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_payload", {out_op_type, out_rd, out_rs1, out_rs2, out_imm, out_pc, out_illegal}, 0);
    chk("reset_count", illegal_count, 0);
    chk("reset_state", dbg_state, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // latency: visible right after the accepting edge
    out_ready = 1'b0;
    send_addi();
    chk("addi_latency_valid", out_valid, 1);
    out_ready = 1'b1;

    // back-to-back directed vectors
    send_sw();
    send(32'hFE000EE3, B_TYPE, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0);
    send(32'h123452B7, U_TYPE, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0);
    send_add();
    send_jal();
    send(32'h300312F3, SYS_TYPE, 5'd5, 5'd6, 5'd0, 32'h00000300, 1'b0);
    send_lw();
    send(32'h00000017, U_TYPE, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0);
    drain();

    // illegal opcodes and saturation
    send_ill0();
    send_ill_fp();
    drain();
    chk("illegal_count_2", illegal_count, 2);
    for (int i = 0; i < 300; i++) begin
      send_ill0();
      send_ill_fp();
    end
    drain();
    chk("illegal_count_sat", illegal_count, 255);

    // backpressure: two accepted, third held
    out_ready = 1'b0;
    send_add();
    send_lw();
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_state_two", dbg_state, 2);
    in_valid = 1'b1;
    in_instr = 32'h008000EF;
    in_pc    = pc_ctr;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_still_full", in_ready, 0);
    chk("bp_payload_stable", {out_rd, out_imm}, {5'd3, 32'h0});
    out_ready = 1'b1;
    send_jal();
    drain();

    // reset mid-stream with two entries buffered
    out_ready = 1'b0;
    send_add();
    send_ill0();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h0020A423;
    @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    chk("rst_mid_count", illegal_count, 0);
    chk("rst_mid_payload", {out_rd, out_rs1, out_imm, out_illegal}, 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_mid_ready_after", in_ready, 1);
    @(posedge clk);
    #1;
    chk("rst_mid_empty", out_valid, 0);

    // flush in ONE with an illegal input: dropped and not counted
    out_ready = 1'b0;
    send_addi();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00000000;
    @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_one_out_valid", out_valid, 0);
    chk("flush_one_count", illegal_count, 0);

    // flush in TWO with in_valid high
    send_addi();
    send_sw();
    chk("flush_two_state", dbg_state, 2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h123452B7;
    @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_two_out_valid", out_valid, 0);
    chk("flush_two_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send_add();
    drain();
    chk("final_count", illegal_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
